rx_frame_sched: RTL and testbench

Read-side scheduler for the Rx frame ring buffer in the 250 MHz domain. Detects committed frames, fetches each frame's length header, and splits the payload into bounded DMA bursts for the downstream DMA/TLP engine. Shares the ring's single read port between its own header fetches and the engine's payload reads. When a frame is fully transferred, it frees the ring space by publishing a new committed read address with an update strobe for the MAC-side writer.

---
 rtl/rx_frame_sched_pkg.sv | 34 +++
 rtl/rx_frame_sched_ptr_sync.sv | 31 +++
 rtl/rx_frame_sched.sv | 180 ++++++++++++++++++
 tb/tb_rx_frame_sched.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_sched_pkg.sv
// Shared definitions for the Rx frame ring read-side scheduler.
package rx_frame_sched_pkg;

    // Scheduler states
    typedef enum logic [2:0] {
        StIdle,
        StHdrW1,
        StHdrW2,
        StHdrCap,
        StReq,
        StWait,
        StCommit,
        StNotify
    } sched_state_e;

    // Byte count field inside the 64-bit frame header word
    localparam int unsigned HDR_BYTES_MSB = 63;
    localparam int unsigned HDR_BYTES_LSB = 32;

    // Largest legal frame byte count
    localparam int unsigned HDR_MAX_BYTES = 9600;

    // Strobe timing after a commit: quiet cycles, then strobe-high cycles
    localparam int unsigned NOTIFY_GAP = 2;
    localparam int unsigned NOTIFY_LEN = 4;

    // Payload length in qwords, evaluated at 16-bit width
    function automatic logic [15:0] bytes_to_qwords(input logic [31:0] bytes);
        logic [15:0] sum;
        sum = bytes[15:0] + 16'd7;
        return sum >> 3;
    endfunction

endpackage

// File: rtl/rx_frame_sched_ptr_sync.sv
// Two-flop synchronizer for a multi-bit pointer; the output only loads when
// two consecutive samples agree, so skewed bit transitions are never taken.
module ptr_sync_stable #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] s0_q, s1_q, ptr_q;

    // Sample chain plus equal-sample load of the stable pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q  <= '0;
            s1_q  <= '0;
            ptr_q <= '0;
        end else begin
            s0_q <= ptr_i;
            s1_q <= s0_q;
            if (s1_q == s0_q) begin
                ptr_q <= s1_q;
            end
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rx_frame_sched.sv
// Read-side scheduler for the Rx frame ring: fetches frame headers, splits
// payload into DMA bursts and frees ring space once a frame is transferred.
module rx_frame_sched
    import rx_frame_sched_pkg::*;
#(
    parameter int unsigned AW        = 10,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned MAX_BYTES = HDR_MAX_BYTES
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] commited_wr_address,
    output logic [AW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    input  logic [AW-1:0] dma_rd_addr,
    output logic          dma_req,
    output logic [AW-1:0] dma_addr,
    output logic [6:0]    dma_qwords,
    input  logic          dma_ack,
    input  logic          dma_done,
    input  logic          enable,
    output logic [AW-1:0] commited_rd_address,
    output logic          rd_addr_updated,
    output logic          hdr_err,
    output logic [31:0]   frames_sent
);

    localparam int unsigned NotifyLast = NOTIFY_GAP + NOTIFY_LEN - 1;

    sched_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [15:0]   rem_q, rem_d;
    logic [AW-1:0] next_rd_q, next_rd_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          hdr_err_q, hdr_err_d;
    logic [31:0]   frames_q, frames_d;
    logic          flush_q, flush_d;
    logic [2:0]    ntf_cnt_q, ntf_cnt_d;

    logic [31:0]   hdr_bytes;
    logic          hdr_legal;
    logic [15:0]   hdr_qw;
    logic [6:0]    burst_qw;
    logic          frame_avail;
    logic          unused_rd_bits;

    ptr_sync_stable #(
        .W (AW)
    ) u_wr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .ptr_i   (commited_wr_address),
        .ptr_o   (wr_ptr)
    );

    assign hdr_bytes      = rd_data[HDR_BYTES_MSB:HDR_BYTES_LSB];
    assign hdr_legal      = (hdr_bytes != 32'd0) && (hdr_bytes <= 32'(MAX_BYTES));
    assign hdr_qw         = bytes_to_qwords(hdr_bytes);
    assign frame_avail    = (wr_ptr != rd_ptr_q) && enable;
    assign unused_rd_bits = ^rd_data[HDR_BYTES_LSB-1:0];

    // Current burst size: remaining qwords clipped to the burst limit
    always_comb begin
        burst_qw = rem_q[6:0];
        if (rem_q > 16'(MAX_BURST)) begin
            burst_qw = 7'(MAX_BURST);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            rem_q     <= '0;
            next_rd_q <= '0;
            rd_ptr_q  <= '0;
            hdr_err_q <= 1'b0;
            frames_q  <= '0;
            flush_q   <= 1'b0;
            ntf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            next_rd_q <= next_rd_d;
            rd_ptr_q  <= rd_ptr_d;
            hdr_err_q <= hdr_err_d;
            frames_q  <= frames_d;
            flush_q   <= flush_d;
            ntf_cnt_q <= ntf_cnt_d;
        end
    end

    // Next-state logic: header fetch, burst issue, commit and notify
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        next_rd_d = next_rd_q;
        rd_ptr_d  = rd_ptr_q;
        hdr_err_d = hdr_err_q;
        frames_d  = frames_q;
        flush_d   = flush_q;
        ntf_cnt_d = ntf_cnt_q;

        case (state_q)
            StIdle: begin
                if (frame_avail) begin
                    flush_d = 1'b0;
                    state_d = StHdrW1;
                end
            end
            StHdrW1: state_d = StHdrW2;
            StHdrW2: state_d = StHdrCap;
            StHdrCap: begin
                if (hdr_legal) begin
                    rem_d   = hdr_qw;
                    ptr_d   = rd_ptr_q + AW'(1);
                    state_d = StReq;
                end else begin
                    // Corrupt header: drop everything the writer has committed
                    hdr_err_d = 1'b1;
                    next_rd_d = wr_ptr;
                    flush_d   = 1'b1;
                    state_d   = StCommit;
                end
            end
            StReq: begin
                if (dma_ack) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dma_done) begin
                    ptr_d = ptr_q + AW'(burst_qw);
                    rem_d = rem_q - 16'(burst_qw);
                    if (rem_q == 16'(burst_qw)) begin
                        next_rd_d = ptr_q + AW'(burst_qw);
                        state_d   = StCommit;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StCommit: begin
                rd_ptr_d = next_rd_q;
                if (!flush_q) begin
                    frames_d = frames_q + 32'd1;
                end
                ntf_cnt_d = '0;
                state_d   = StNotify;
            end
            StNotify: begin
                ntf_cnt_d = ntf_cnt_q + 3'd1;
                if (ntf_cnt_q == 3'(NotifyLast)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; the DMA engine owns the read port while a frame is in flight
    always_comb begin
        rd_addr = rd_ptr_q;
        if (state_q == StReq || state_q == StWait) begin
            rd_addr = dma_rd_addr;
        end
        dma_req             = (state_q == StReq);
        dma_addr            = ptr_q;
        dma_qwords          = burst_qw;
        commited_rd_address = rd_ptr_q;
        rd_addr_updated     = (state_q == StNotify) && (ntf_cnt_q >= 3'(NOTIFY_GAP));
        hdr_err             = hdr_err_q;
        frames_sent         = frames_q;
    end

endmodule

// File: tb/tb_rx_frame_sched.sv
// Self-checking bench for rx_frame_sched with a ring memory, a DMA engine
// responder and a frame-level reference model.
module tb_rx_frame_sched;

    localparam int AW   = 10;
    localparam int MB   = 16;
    localparam int RING = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] commited_wr_address;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [AW-1:0] dma_rd_addr;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [6:0]    dma_qwords;
    logic          dma_ack;
    logic          dma_done;
    logic          enable;
    logic [AW-1:0] commited_rd_address;
    logic          rd_addr_updated;
    logic          hdr_err;
    logic [31:0]   frames_sent;

    int n_checks = 0;
    int n_fail   = 0;

    rx_frame_sched #(
        .AW        (AW),
        .MAX_BURST (MB),
        .MAX_BYTES (9600)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .commited_wr_address (commited_wr_address),
        .rd_addr             (rd_addr),
        .rd_data             (rd_data),
        .dma_rd_addr         (dma_rd_addr),
        .dma_req             (dma_req),
        .dma_addr            (dma_addr),
        .dma_qwords          (dma_qwords),
        .dma_ack             (dma_ack),
        .dma_done            (dma_done),
        .enable              (enable),
        .commited_rd_address (commited_rd_address),
        .rd_addr_updated     (rd_addr_updated),
        .hdr_err             (hdr_err),
        .frames_sent         (frames_sent)
    );

    always #2 clk = ~clk;

    // Ring memory with 2-cycle read latency
    logic [63:0] mem [RING];
    logic [63:0] rd_pipe;
    always @(posedge clk) begin
        rd_pipe <= mem[rd_addr];
        rd_data <= rd_pipe;
    end

    // Observed events
    int obs_addr[$];
    int obs_q[$];
    int strb_addr[$];
    int strb_len[$];
    int strb_stable[$];
    int req_unstable = 0;
    int mux_err      = 0;

    // Expected events from the model
    int exp_a[$];
    int exp_q[$];
    int exp_c[$];

    // Engine timing control
    bit rand_timing = 1'b1;
    int ack_wait    = 0;
    int done_wait   = 0;

    // DMA engine responder: acks requests, later pulses done
    logic [AW-1:0] eng_a;
    logic [6:0]    eng_q;
    int            eng_k;
    initial begin
        dma_ack     = 1'b0;
        dma_done    = 1'b0;
        dma_rd_addr = '0;
        forever begin
            @(posedge clk); #1;
            dma_done = 1'b0;
            if (reset_n === 1'b1 && dma_req === 1'b1) begin
                eng_a = dma_addr;
                eng_q = dma_qwords;
                eng_k = rand_timing ? int'($urandom_range(0, 3)) : ack_wait;
                for (int i = 0; i < eng_k && reset_n; i++) begin
                    @(posedge clk); #1;
                    if (reset_n && (dma_req !== 1'b1 || dma_addr !== eng_a ||
                                    dma_qwords !== eng_q))
                        req_unstable++;
                end
                if (!reset_n) continue;
                dma_ack = 1'b1;
                obs_addr.push_back(int'(eng_a));
                obs_q.push_back(int'(eng_q));
                @(posedge clk); #1;
                dma_ack = 1'b0;
                eng_k = rand_timing ? int'($urandom_range(0, 4)) : done_wait;
                for (int i = 0; i < eng_k && reset_n; i++) begin
                    dma_rd_addr = AW'($urandom);
                    #1;
                    if (reset_n && rd_addr !== dma_rd_addr) mux_err++;
                    @(posedge clk); #1;
                end
                if (!reset_n) continue;
                dma_done = 1'b1;
            end
        end
    end

    // Strobe monitor: length, address, and address stability around it
    logic [AW-1:0] mon_h1 = '0, mon_h2 = '0, mon_cur = '0;
    int            mon_len    = 0;
    int            mon_stable = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rd_addr_updated === 1'b1) begin
                if (mon_len == 0) begin
                    mon_cur    = commited_rd_address;
                    mon_stable = (mon_h1 == mon_cur && mon_h2 == mon_cur) ? 1 : 0;
                end else if (commited_rd_address !== mon_cur) begin
                    mon_stable = 0;
                end
                mon_len++;
            end else if (mon_len > 0) begin
                strb_addr.push_back(int'(mon_cur));
                strb_len.push_back(mon_len);
                strb_stable.push_back(mon_stable);
                mon_len = 0;
            end
            mon_h2 = mon_h1;
            mon_h1 = commited_rd_address;
        end
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Frame model: bursts never exceed MB, pointers wrap modulo RING
    function automatic int model_frame(input int h, input int bytes);
        int w;
        int a;
        int q;
        w = (bytes + 7) / 8;
        a = h + 1;
        while (w > 0) begin
            q = (w > MB) ? MB : w;
            exp_a.push_back(a % RING);
            exp_q.push_back(q);
            a += q;
            w -= q;
        end
        exp_c.push_back(a % RING);
        return a % RING;
    endfunction

    function automatic void clear_logs();
        obs_addr.delete();
        obs_q.delete();
        strb_addr.delete();
        strb_len.delete();
        strb_stable.delete();
        exp_a.delete();
        exp_q.delete();
        exp_c.delete();
        req_unstable = 0;
        mux_err      = 0;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        commited_wr_address = '0;
        repeat (3) @(posedge clk);
        #1;
        clear_logs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (strb_addr.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        ok = (strb_addr.size() >= n);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        commited_wr_address = '0;
        #1;
        n_checks++;
        if ({rd_addr, dma_req, dma_addr, dma_qwords, commited_rd_address,
             rd_addr_updated, hdr_err, frames_sent} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%0d req=%0b addr=%0d qw=%0d crd=%0d upd=%0b err=%0b fs=%0d, required all 0",
                     rd_addr, dma_req, dma_addr, dma_qwords, commited_rd_address,
                     rd_addr_updated, hdr_err, frames_sent);
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        bit ok;
        do_reset();
        rand_timing = 1'b1;
        mem[0] = {32'd64, 32'h0};
        void'(model_frame(0, 64));
        commited_wr_address = AW'(9);
        wait_strobes(1, 300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout: got %0d strobes, required 1", strb_addr.size());
        end
        n_checks++;
        if (obs_addr.size() != 1 || obs_addr[0] != 1 || obs_q[0] != 8) begin
            n_fail++;
            $display("FAIL single_burst: got %0d bursts (first addr=%0d q=%0d), required 1 burst addr=1 q=8",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1,
                     (obs_q.size() > 0) ? obs_q[0] : -1);
        end
        n_checks++;
        if (commited_rd_address !== AW'(9)) begin
            n_fail++;
            $display("FAIL single_commit: got %0d, required 9", commited_rd_address);
        end
        n_checks++;
        if (ok && (strb_len[0] != 4 || strb_stable[0] != 1 || strb_addr[0] != 9)) begin
            n_fail++;
            $display("FAIL single_strobe: got len=%0d stable=%0d addr=%0d, required len=4 stable=1 addr=9",
                     strb_len[0], strb_stable[0], strb_addr[0]);
        end
        n_checks++;
        if (frames_sent !== 32'd1 || hdr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_counters: got frames=%0d err=%0b, required frames=1 err=0",
                     frames_sent, hdr_err);
        end
    endtask

    task automatic test_large_frame();
        bit ok;
        int bad;
        clear_logs();
        mem[9] = {32'd1500, 32'h0};
        void'(model_frame(9, 1500));
        commited_wr_address = AW'(198);
        wait_strobes(1, 2000, ok);
        n_checks++;
        if (!ok || obs_addr.size() != exp_a.size()) begin
            n_fail++;
            $display("FAIL large_burst_count: got %0d bursts, required %0d",
                     obs_addr.size(), exp_a.size());
        end
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_a[i] || obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL large_burst[%0d]: got addr=%0d q=%0d, required addr=%0d q=%0d",
                         i, obs_addr[i], obs_q[i], exp_a[i], exp_q[i]);
            end
        end
        n_checks++;
        if (commited_rd_address !== AW'(exp_c[0]) || frames_sent !== 32'd2) begin
            n_fail++;
            $display("FAIL large_commit: got addr=%0d frames=%0d, required addr=%0d frames=2",
                     commited_rd_address, frames_sent, exp_c[0]);
        end
        n_checks++;
        if (mux_err != 0) begin
            n_fail++;
            $display("FAIL read_port_mux: got %0d mismatches, required 0", mux_err);
        end
    endtask

    task automatic test_bad_header();
        bit ok;
        do_reset();
        mem[0] = {32'd9601, 32'h0};
        commited_wr_address = AW'(500);
        wait_strobes(1, 300, ok);
        n_checks++;
        if (!ok || commited_rd_address !== AW'(500)) begin
            n_fail++;
            $display("FAIL bad9601_flush: got addr=%0d strobes=%0d, required addr=500 strobes=1",
                     commited_rd_address, strb_addr.size());
        end
        mem[500] = {32'd0, 32'h0};
        commited_wr_address = AW'(1020);
        wait_strobes(2, 300, ok);
        n_checks++;
        if (!ok || commited_rd_address !== AW'(1020)) begin
            n_fail++;
            $display("FAIL bad0_flush: got addr=%0d strobes=%0d, required addr=1020 strobes=2",
                     commited_rd_address, strb_addr.size());
        end
        n_checks++;
        if (hdr_err !== 1'b1 || frames_sent !== 32'd0 || obs_addr.size() != 0) begin
            n_fail++;
            $display("FAIL bad_flags: got err=%0b frames=%0d bursts=%0d, required err=1 frames=0 bursts=0",
                     hdr_err, frames_sent, obs_addr.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        mem[1020] = {32'd100, 32'h0};
        void'(model_frame(1020, 100));
        commited_wr_address = AW'(10);
        wait_strobes(1, 300, ok);
        n_checks++;
        if (!ok || obs_addr.size() != 1 || obs_addr[0] != 1021 || obs_q[0] != 13) begin
            n_fail++;
            $display("FAIL wrap_burst: got %0d bursts (addr=%0d q=%0d), required 1 burst addr=1021 q=13",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1,
                     (obs_q.size() > 0) ? obs_q[0] : -1);
        end
        n_checks++;
        if (commited_rd_address !== AW'(exp_c[0]) || frames_sent !== 32'd1 ||
            hdr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_commit: got addr=%0d frames=%0d err=%0b, required addr=%0d frames=1 err=1",
                     commited_rd_address, frames_sent, hdr_err, exp_c[0]);
        end
    endtask

    task automatic test_ack_holdoff_enable();
        bit ok;
        int c;
        do_reset();
        rand_timing = 1'b0;
        ack_wait    = 20;
        done_wait   = 2;
        mem[0] = {32'd300, 32'h0};
        void'(model_frame(0, 300));
        commited_wr_address = AW'(39);
        c = 0;
        while (obs_addr.size() < 1 && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        enable = 1'b0;
        wait_strobes(1, 500, ok);
        n_checks++;
        if (!ok || obs_addr.size() != 3 || commited_rd_address !== AW'(exp_c[0])) begin
            n_fail++;
            $display("FAIL holdoff_complete: got bursts=%0d addr=%0d, required bursts=3 addr=%0d",
                     obs_addr.size(), commited_rd_address, exp_c[0]);
        end
        for (int i = 0; i < obs_addr.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_a[i] || obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL holdoff_burst[%0d]: got addr=%0d q=%0d, required addr=%0d q=%0d",
                         i, obs_addr[i], obs_q[i], exp_a[i], exp_q[i]);
            end
        end
        n_checks++;
        if (req_unstable != 0) begin
            n_fail++;
            $display("FAIL holdoff_stable: got %0d unstable cycles, required 0", req_unstable);
        end
        mem[39] = {32'd64, 32'h0};
        void'(model_frame(39, 64));
        commited_wr_address = AW'(48);
        repeat (60) @(posedge clk);
        #1;
        n_checks++;
        if (obs_addr.size() != 3 || strb_addr.size() != 1 ||
            commited_rd_address !== AW'(39)) begin
            n_fail++;
            $display("FAIL enable_low_idle: got bursts=%0d strobes=%0d addr=%0d, required bursts=3 strobes=1 addr=39",
                     obs_addr.size(), strb_addr.size(), commited_rd_address);
        end
        enable = 1'b1;
        wait_strobes(2, 500, ok);
        n_checks++;
        if (!ok || commited_rd_address !== AW'(48) || frames_sent !== 32'd2) begin
            n_fail++;
            $display("FAIL enable_resume: got addr=%0d frames=%0d, required addr=48 frames=2",
                     commited_rd_address, frames_sent);
        end
        ack_wait = 0;
        done_wait = 0;
        rand_timing = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int c;
        do_reset();
        rand_timing = 1'b0;
        ack_wait    = 0;
        done_wait   = 1000;
        mem[0] = {32'd64, 32'h0};
        commited_wr_address = AW'(9);
        c = 0;
        while (obs_addr.size() < 1 && c < 200) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_addr, dma_req, dma_addr, dma_qwords, commited_rd_address,
             rd_addr_updated, hdr_err, frames_sent} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rd=%0d req=%0b addr=%0d qw=%0d crd=%0d upd=%0b err=%0b fs=%0d, required all 0",
                     rd_addr, dma_req, dma_addr, dma_qwords, commited_rd_address,
                     rd_addr_updated, hdr_err, frames_sent);
        end
        done_wait = 1;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        @(negedge clk);
        reset_n = 1'b1;
        wait_strobes(1, 300, ok);
        n_checks++;
        if (!ok || obs_addr.size() != 1 || obs_addr[0] != 1 || obs_q[0] != 8 ||
            commited_rd_address !== AW'(9) || frames_sent !== 32'd1) begin
            n_fail++;
            $display("FAIL midreset_reread: got bursts=%0d addr=%0d frames=%0d, required bursts=1 at 1 addr=9 frames=1",
                     obs_addr.size(), commited_rd_address, frames_sent);
        end
        rand_timing = 1'b1;
        done_wait   = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int h;
        int bytes;
        int nf;
        do_reset();
        rand_timing = 1'b1;
        nf = 6;
        h  = 0;
        for (int i = 0; i < nf; i++) begin
            bytes = int'($urandom_range(1, 1000));
            mem[h] = {32'(bytes), 32'h0};
            h = model_frame(h, bytes);
        end
        commited_wr_address = AW'(h);
        wait_strobes(nf, 8000, ok);
        n_checks++;
        if (!ok || obs_addr.size() != exp_a.size()) begin
            n_fail++;
            $display("FAIL b2b_counts: got strobes=%0d bursts=%0d, required strobes=%0d bursts=%0d",
                     strb_addr.size(), obs_addr.size(), nf, exp_a.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_a.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_a[i] || obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_burst[%0d]: got addr=%0d q=%0d, required addr=%0d q=%0d",
                         i, obs_addr[i], obs_q[i], exp_a[i], exp_q[i]);
            end
        end
        for (int i = 0; i < strb_addr.size() && i < exp_c.size(); i++) begin
            n_checks++;
            if (strb_addr[i] != exp_c[i] || strb_len[i] != 4 || strb_stable[i] != 1) begin
                n_fail++;
                $display("FAIL b2b_strobe[%0d]: got addr=%0d len=%0d stable=%0d, required addr=%0d len=4 stable=1",
                         i, strb_addr[i], strb_len[i], strb_stable[i], exp_c[i]);
            end
        end
        n_checks++;
        if (frames_sent !== 32'(nf) || hdr_err !== 1'b0 || mux_err != 0) begin
            n_fail++;
            $display("FAIL b2b_final: got frames=%0d err=%0b mux=%0d, required frames=%0d err=0 mux=0",
                     frames_sent, hdr_err, mux_err, nf);
        end
    endtask

    initial begin
        for (int i = 0; i < RING; i++) mem[i] = 64'h0;
        test_reset();
        test_single_frame();
        test_large_frame();
        test_bad_header();
        test_wrap();
        test_ack_holdoff_enable();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
